// File: rtl/upsample_stuffer.sv
// Zero-stuffing upsampler: buffers base-rate samples in a small FIFO and emits
// each one followed by L-1 zeros over a valid/ready output handshake.
module upsample_stuffer #(
  parameter int DATA_W = 16,
  parameter int L      = 2,
  parameter int DEPTH  = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       LOCKED,
  input  logic [DATA_W-1:0]          IN_DATA,
  input  logic                       IN_VALID,
  output logic                       IN_READY,
  output logic [DATA_W-1:0]          OUT_DATA,
  output logic                       OUT_VALID,
  input  logic                       OUT_READY,
  output logic [$clog2(DEPTH):0]     LEVEL
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int PHW = $clog2(L);
  localparam logic [PHW-1:0] PH_LAST = PHW'(L - 1);
  localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t              state_q, state_d;
  logic [PHW-1:0]      ph_q, ph_d;
  logic [LW-1:0]       level_q, level_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                push;
  logic                pop;
  logic                flush;

  // Loss of lock behaves like a reset of everything except FIFO storage.
  assign flush    = RST || !LOCKED;
  assign IN_READY = !flush && (level_q != FULL_LVL);
  assign push     = IN_VALID && IN_READY;

  assign OUT_VALID = (state_q == EMIT);
  assign OUT_DATA  = out_data_q;
  assign LEVEL     = level_q;

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    out_data_d = out_data_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop        = 1'b1;
          out_data_d = mem[rd_ptr_q];
          ph_d       = '0;
          state_d    = EMIT;
        end
      end
      EMIT: begin
        if (OUT_READY) begin
          if (ph_q != PH_LAST) begin
            ph_d       = ph_q + PHW'(1);
            out_data_d = '0;
          end else if (level_q != '0) begin
            // Chain straight into the next sample so the stream has no bubble.
            pop        = 1'b1;
            out_data_d = mem[rd_ptr_q];
            ph_d       = '0;
          end else begin
            out_data_d = '0;
            ph_d       = '0;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        ph_d       = '0;
        out_data_d = '0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (flush) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_q] <= IN_DATA;
    end
  end

endmodule
